// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the iteration counter sizing helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    // Ceiling log2; the counter is sized with clog2(WIDTH+1) so it can hold WIDTH.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit: issue, MTHI/MTLO writes,
// hazard signalling and the architectural HI/LO registers.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wdata, rd_req,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata, rd_req,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/muldiv_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. acc holds product-high/remainder, sreg product-low/quotient.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             last
);

    localparam int CNT_W = clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] breg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sreg_next;

    // When the trial subtraction succeeds the true difference is below the
    // divisor, so the modular WIDTH-bit difference is exact.
    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (sreg[0] ? breg : {WIDTH{1'b0}})};
        div_shift = {acc, sreg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, breg});
        div_rem   = div_shift[WIDTH-1:0] - breg;
        acc_next  = mul_sum[WIDTH:1];
        sreg_next = {mul_sum[0], sreg[WIDTH-1:1]};
        if (mode) begin
            if (div_ge) begin
                acc_next  = div_rem;
                sreg_next = {sreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next  = div_shift[WIDTH-1:0];
                sreg_next = {sreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            sreg  <= '0;
            breg  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            sreg  <= a_mag;
            breg  <= b_mag;
            count <= '0;
        end else if (step) begin
            acc   <= acc_next;
            sreg  <= sreg_next;
            count <= count + CNT_W'(1);
        end
    end

    assign res_hi = acc;
    assign res_lo = sreg;
    assign last   = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: issue FSM, sign handling around the
// unsigned core, HI/LO registers with MTHI/MTLO and the MFHI/MFLO stall.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clock,
    input  logic  reset,
    muldiv_if.slave bus
);

    state_t state;
    state_t state_next;

    logic             accept;
    logic             step;
    logic             busy;
    logic             is_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic             is_div;
    logic [WIDTH-1:0] a_raw;

    logic [WIDTH-1:0]   core_hi;
    logic [WIDTH-1:0]   core_lo;
    logic               core_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_commit;
    logic [WIDTH-1:0]   lo_commit;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides everything, including a start in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = bus.op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                step = 1'b1;
                if (core_last) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            step       = 1'b0;
        end
    end

    assign is_signed = ~bus.op[0];
    assign a_mag     = (is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign b_mag     = (is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            a_raw    <= '0;
        end else if (accept) begin
            neg_res  <= is_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_rem  <= is_signed & bus.src_a[WIDTH-1];
            div_zero <= (bus.src_b == '0);
            is_div   <= bus.op[1];
            a_raw    <= bus.src_a;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (accept),
        .step   (step),
        .mode   (state == DIV),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (core_hi),
        .res_lo (core_lo),
        .last   (core_last)
    );

    // Divide-by-zero bypasses the magnitude result and returns the raw dividend.
    always_comb begin
        prod_fix  = neg_res ? -{core_hi, core_lo} : {core_hi, core_lo};
        quot_fix  = neg_res ? -core_lo : core_lo;
        rem_fix   = neg_rem ? -core_hi : core_hi;
        hi_commit = prod_fix[2*WIDTH-1:WIDTH];
        lo_commit = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_commit = a_raw;
                lo_commit = {WIDTH{1'b1}};
            end else begin
                hi_commit = rem_fix;
                lo_commit = quot_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == FIX && !bus.flush) begin
                hi_q   <= hi_commit;
                lo_q   <= lo_commit;
                done_q <= 1'b1;
            end else if (state == IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.stall = bus.rd_req & (busy | bus.start);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference: plain signed/unsigned arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.flush  = 1'b0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;
        bus.rd_req = 1'b0;
    endtask

    // Issues one operation and waits (bounded) for done; measures only.
    task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] got_hi, output logic [31:0] got_lo,
                                  output int edges, output int busy_cycles);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start   = 1'b0;
        edges       = 0;
        busy_cycles = 0;
        while (!bus.done && edges < 200) begin
            if (bus.busy) busy_cycles++;
            tick();
            edges++;
        end
        got_hi = bus.hi;
        got_lo = bus.lo;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.rd_req = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", bus.lo); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.stall); end
        bus.rd_req = 1'b0;
        tick();
    endtask

    logic [1:0]  dir_op [8] = '{OP_MULTU, OP_MULT, OP_MULT, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_MULTU};
    logic [31:0] dir_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                                32'h8000_0000, 32'd5, 32'hFFFF_FFF9, 32'd0};
    logic [31:0] dir_b  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                                32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0001_2345};
    logic [31:0] dir_hi [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                                32'h0, 32'd5, 32'hFFFF_FFF9, 32'h0};
    logic [31:0] dir_lo [8] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

    task automatic test_directed();
        logic [31:0] got_hi, got_lo;
        int edges, busy_cycles;
        for (int i = 0; i < 8; i++) begin
            issue_and_wait(dir_op[i], dir_a[i], dir_b[i], got_hi, got_lo, edges, busy_cycles);
            checks++; if (got_hi !== dir_hi[i]) begin failures++; $display("[TB] FAIL directed%0d_hi got=%h exp=%h", i, got_hi, dir_hi[i]); end
            checks++; if (got_lo !== dir_lo[i]) begin failures++; $display("[TB] FAIL directed%0d_lo got=%h exp=%h", i, got_lo, dir_lo[i]); end
            checks++; if (edges !== W + 1) begin failures++; $display("[TB] FAIL directed%0d_latency got=%0d exp=%0d", i, edges, W + 1); end
            checks++; if (busy_cycles !== W + 1) begin failures++; $display("[TB] FAIL directed%0d_busy got=%0d exp=%0d", i, busy_cycles, W + 1); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL directed%0d_busy_in_done got=%b exp=0", i, bus.busy); end
            tick();
            checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL directed%0d_done_width got=%b exp=0", i, bus.done); end
        end
    endtask

    task automatic test_random();
        logic [31:0] got_hi, got_lo, a, b;
        logic [1:0]  op;
        logic [63:0] exp;
        int edges, busy_cycles;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp = model(op, a, b);
            issue_and_wait(op, a, b, got_hi, got_lo, edges, busy_cycles);
            checks++; if (got_hi !== exp[63:32]) begin failures++; $display("[TB] FAIL random%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, got_hi, exp[63:32]); end
            checks++; if (got_lo !== exp[31:0]) begin failures++; $display("[TB] FAIL random%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, got_lo, exp[31:0]); end
            checks++; if (edges !== W + 1) begin failures++; $display("[TB] FAIL random%0d_latency got=%0d exp=%0d", i, edges, W + 1); end
        end
        tick();
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        int edges, stall_cycles;
        exp = model(OP_DIVU, 32'd1000, 32'd33);
        bus.rd_req = 1'b1;
        bus.start  = 1'b1;
        bus.op     = OP_DIVU;
        bus.src_a  = 32'd1000;
        bus.src_b  = 32'd33;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL stall_start_cycle got=%b exp=1", bus.stall); end
        tick();
        bus.start    = 1'b0;
        edges        = 0;
        stall_cycles = 0;
        while (!bus.done && edges < 200) begin
            if (bus.stall) stall_cycles++;
            tick();
            edges++;
        end
        checks++; if (stall_cycles !== W + 1) begin failures++; $display("[TB] FAIL stall_cycles got=%0d exp=%0d", stall_cycles, W + 1); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL stall_done_cycle got=%b exp=0", bus.stall); end
        checks++; if ({bus.hi, bus.lo} !== exp) begin failures++; $display("[TB] FAIL stall_result got=%h%h exp=%h", bus.hi, bus.lo, exp); end
        bus.rd_req = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] got_hi, got_lo;
        int edges, busy_cycles, done_seen;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h11;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h22;
        tick();
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'h11) begin failures++; $display("[TB] FAIL mthi got=%h exp=11", bus.hi); end
        checks++; if (bus.lo !== 32'h22) begin failures++; $display("[TB] FAIL mtlo got=%h exp=22", bus.lo); end
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.src_a = 32'd50;
        bus.src_b = 32'd3;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got=%b exp=0", bus.busy); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin failures++; $display("[TB] FAIL flush_no_done got=%0d exp=0", done_seen); end
        checks++; if (bus.hi !== 32'h11) begin failures++; $display("[TB] FAIL flush_hi got=%h exp=11", bus.hi); end
        checks++; if (bus.lo !== 32'h22) begin failures++; $display("[TB] FAIL flush_lo got=%h exp=22", bus.lo); end
        issue_and_wait(OP_DIVU, 32'd100, 32'd7, got_hi, got_lo, edges, busy_cycles);
        checks++; if (got_lo !== 32'd14) begin failures++; $display("[TB] FAIL after_flush_lo got=%h exp=e", got_lo); end
        checks++; if (got_hi !== 32'd2) begin failures++; $display("[TB] FAIL after_flush_hi got=%h exp=2", got_hi); end
        tick();
    endtask

    task automatic test_mt_timing();
        int edges;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hABCD;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'hABCD) begin failures++; $display("[TB] FAIL mt_with_start_hi got=%h exp=abcd", bus.hi); end
        checks++; if (bus.lo !== 32'hABCD) begin failures++; $display("[TB] FAIL mt_with_start_lo got=%h exp=abcd", bus.lo); end
        repeat (3) tick();
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5555;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'hABCD) begin failures++; $display("[TB] FAIL mt_busy_dropped_hi got=%h exp=abcd", bus.hi); end
        checks++; if (bus.lo !== 32'hABCD) begin failures++; $display("[TB] FAIL mt_busy_dropped_lo got=%h exp=abcd", bus.lo); end
        edges = 4;
        while (!bus.done && edges < 200) begin
            tick();
            edges++;
        end
        checks++; if (edges !== W + 1) begin failures++; $display("[TB] FAIL mt_latency got=%0d exp=%0d", edges, W + 1); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin failures++; $display("[TB] FAIL mt_overwrite got=%h/%h exp=0/2a", bus.hi, bus.lo); end
        tick();
    endtask

    task automatic test_second_start();
        logic [31:0] a, b;
        logic [63:0] exp;
        int edges;
        a   = $urandom;
        b   = $urandom;
        exp = model(OP_MULT, a, b);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd9;
        bus.src_b = 32'd4;
        tick();
        bus.start = 1'b0;
        edges = 6;
        while (!bus.done && edges < 200) begin
            tick();
            edges++;
        end
        checks++; if (edges !== W + 1) begin failures++; $display("[TB] FAIL second_start_latency got=%0d exp=%0d", edges, W + 1); end
        checks++; if ({bus.hi, bus.lo} !== exp) begin failures++; $display("[TB] FAIL second_start_result got=%h%h exp=%h", bus.hi, bus.lo, exp); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL second_start_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_hi, got_lo;
        logic [63:0] exp1, exp2;
        int edges, busy_cycles;
        exp1 = model(OP_DIV, 32'hFFFF_FF00, 32'd17);
        exp2 = model(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        issue_and_wait(OP_DIV, 32'hFFFF_FF00, 32'd17, got_hi, got_lo, edges, busy_cycles);
        checks++; if ({got_hi, got_lo} !== exp1) begin failures++; $display("[TB] FAIL b2b_first got=%h%h exp=%h", got_hi, got_lo, exp1); end
        issue_and_wait(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, got_hi, got_lo, edges, busy_cycles);
        checks++; if ({got_hi, got_lo} !== exp2) begin failures++; $display("[TB] FAIL b2b_second got=%h%h exp=%h", got_hi, got_lo, exp2); end
        checks++; if (edges !== W + 1) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", edges, W + 1); end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h77;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'h1234;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_mid_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin failures++; $display("[TB] FAIL reset_mid_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_flush();
        test_mt_timing();
        test_second_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
